index_register_bank: RTL and testbench

- Parametrised successor to the single X/Y index register.
- Holds NUM_REGS index registers of WIDTH bits each. Each register can be loaded from the accumulator or the data bus, cleared, incremented, decremented, offset by a signed step, or copied from another register.
- Sits beside the ALU and accumulator and feeds the address generator through an independent read port.
- Supplies zero and wrap status to the control unit for loop and array-walk instructions.

---
 rtl/index_register_bank_pkg.sv | 13 +
 rtl/index_register_bank_if.sv | 20 ++
 rtl/index_register_bank_alu.sv | 34 +++
 rtl/index_register_bank.sv | 42 ++++
 tb/tb_index_register_bank.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/index_register_bank_pkg.sv
// index_reg_pkg: op codes and shared widths for the index register bank.
package index_reg_pkg;
  localparam int OP_W = 3;
  localparam int DEF_WIDTH = 16;
  localparam logic [OP_W-1:0] OP_NOP       = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD_ACC  = 3'd1;
  localparam logic [OP_W-1:0] OP_LOAD_DATA = 3'd2;
  localparam logic [OP_W-1:0] OP_INC       = 3'd3;
  localparam logic [OP_W-1:0] OP_DEC       = 3'd4;
  localparam logic [OP_W-1:0] OP_STEP      = 3'd5;
  localparam logic [OP_W-1:0] OP_COPY      = 3'd6;
  localparam logic [OP_W-1:0] OP_CLEAR     = 3'd7;
endpackage

// File: rtl/index_register_bank_if.sv
// index_register_bank_if: op/select/data request and read/status response of the bank.
interface index_register_bank_if #(
  parameter int WIDTH = index_reg_pkg::DEF_WIDTH,
  parameter int SEL_W = 1
);
  logic [index_reg_pkg::OP_W-1:0] op;
  logic [SEL_W-1:0] wr_sel;
  logic [SEL_W-1:0] src_sel;
  logic [SEL_W-1:0] rd_sel;
  logic [WIDTH-1:0] acc_val;
  logic [WIDTH-1:0] data_val;
  logic [WIDTH-1:0] out;
  logic zero;
  logic wrap;
  logic busy_err;
  modport master (output op, wr_sel, src_sel, rd_sel, acc_val, data_val,
                  input out, zero, wrap, busy_err);
  modport slave (input op, wr_sel, src_sel, rd_sel, acc_val, data_val,
                 output out, zero, wrap, busy_err);
endinterface

// File: rtl/index_register_bank_alu.sv
// index_reg_alu: next value and wrap flag for one index register.
module index_reg_alu
  import index_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] old,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] acc_val,
  input  logic [WIDTH-1:0] data_val,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);
  logic [WIDTH:0] inc, dec, sum;
  assign inc = {1'b0, old} + {{WIDTH{1'b0}}, 1'b1};
  assign dec = {1'b0, old} - {{WIDTH{1'b0}}, 1'b1};
  assign sum = {1'b0, old} + {1'b0, data_val};
  always_comb begin
    nxt = old;
    wrap = 1'b0;
    case (op)
      OP_LOAD_ACC:  nxt = acc_val;
      OP_LOAD_DATA: nxt = data_val;
      OP_INC:       {wrap, nxt} = inc;
      OP_DEC:       {wrap, nxt} = dec;
      // a negative step wraps exactly when the unsigned add does not carry
      OP_STEP:      {wrap, nxt} = {sum[WIDTH] ^ data_val[WIDTH-1], sum[WIDTH-1:0]};
      OP_COPY:      nxt = src;
      OP_CLEAR:     nxt = '0;
      default:      nxt = old;
    endcase
  end
endmodule

// File: rtl/index_register_bank.sv
// index_register_bank: NUM_REGS index registers with one op per cycle and a free read port.
module index_register_bank
  import index_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_REGS = 2,
  parameter int SEL_W = 1
) (
  input logic clk,
  input logic reset,
  index_register_bank_if.slave bus
);
  localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(NUM_REGS);
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] old, src, nxt;
  logic sel_ok, alu_wrap;
  assign sel_ok = ({1'b0, bus.wr_sel} < LIMIT) && ({1'b0, bus.src_sel} < LIMIT);
  assign old = sel_ok ? regs[bus.wr_sel] : '0;
  assign src = sel_ok ? regs[bus.src_sel] : '0;
  index_reg_alu #(.WIDTH(WIDTH)) alu (
    .op(bus.op),
    .old(old),
    .src(src),
    .acc_val(bus.acc_val),
    .data_val(bus.data_val),
    .nxt(nxt),
    .wrap(alu_wrap)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bus.wrap <= 1'b0;
      bus.busy_err <= 1'b0;
    end else begin
      if (sel_ok && bus.op != OP_NOP) regs[bus.wr_sel] <= nxt;
      bus.wrap <= sel_ok && alu_wrap;
      bus.busy_err <= !sel_ok && bus.op != OP_NOP;
    end
  end
  assign bus.out = ({1'b0, bus.rd_sel} < LIMIT) ? regs[bus.rd_sel] : '0;
  assign bus.zero = bus.out == '0;
endmodule

// File: tb/tb_index_register_bank.sv
// tb_index_register_bank: random and directed checks of two- and three-register banks against an arithmetic model.
module tb_index_register_bank;
  import index_reg_pkg::*;
  logic clk, reset;
  int n_cmp = 0, n_err = 0;
  logic [15:0] m2 [2];
  logic [15:0] m3 [3];
  bit mw2, mw3, mb3;
  index_register_bank_if #(.WIDTH(16), .SEL_W(1)) b2 ();
  index_register_bank_if #(.WIDTH(16), .SEL_W(2)) b3 ();
  index_register_bank #(.WIDTH(16), .NUM_REGS(2), .SEL_W(1)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  index_register_bank #(.WIDTH(16), .NUM_REGS(3), .SEL_W(2)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));
  initial begin
    clk = 0;
    #5;
    forever #5 clk = ~clk;
  end
  function automatic void calc(input logic [2:0] op, input logic [15:0] old, src, acc, data,
                               output logic [15:0] nv, output bit w);
    int s;
    nv = old;
    w = 0;
    s = int'(old);
    case (op)
      3'd1: nv = acc;
      3'd2: nv = data;
      3'd3: s = int'(old) + 1;
      3'd4: s = int'(old) - 1;
      3'd5: s = int'(old) + int'($signed(data));
      3'd6: nv = src;
      3'd7: nv = 16'd0;
      default: ;
    endcase
    if (op inside {3'd3, 3'd4, 3'd5}) begin
      nv = 16'(s);
      w = (s < 0) || (s > 65535);
    end
  endfunction
  task automatic do2(input logic [2:0] op, input int wr, src, input logic [15:0] acc, data);
    logic [15:0] nv;
    bit w;
    b2.op = op; b2.wr_sel = 1'(wr); b2.src_sel = 1'(src); b2.acc_val = acc; b2.data_val = data;
    calc(op, m2[wr], m2[src], acc, data, nv, w);
    @(posedge clk); #1;
    m2[wr] = nv;
    mw2 = w;
  endtask
  task automatic do3(input logic [2:0] op, input int wr, src, input logic [15:0] acc, data);
    logic [15:0] nv;
    bit w, ok;
    ok = wr < 3 && src < 3;
    b3.op = op; b3.wr_sel = 2'(wr); b3.src_sel = 2'(src); b3.acc_val = acc; b3.data_val = data;
    nv = 0; w = 0;
    if (ok) calc(op, m3[wr], m3[src], acc, data, nv, w);
    @(posedge clk); #1;
    if (ok) m3[wr] = nv;
    mw3 = ok && w;
    mb3 = !ok && op != 3'd0;
  endtask
  task automatic test_reset;
    reset = 0;
    b2.op = OP_LOAD_ACC; b2.wr_sel = 0; b2.src_sel = 0; b2.rd_sel = 0; b2.acc_val = 16'h0002; b2.data_val = 0;
    b3.op = OP_LOAD_ACC; b3.wr_sel = 0; b3.src_sel = 0; b3.rd_sel = 0; b3.acc_val = 16'h0002; b3.data_val = 0;
    m2 = '{default: 16'h0}; m3 = '{default: 16'h0};
    mw2 = 0; mw3 = 0; mb3 = 0;
    #12;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) begin
        b2.rd_sel = 1'(r);
        #1;
        n_cmp++;
        if (b2.out !== 16'h0 || b2.zero !== 1'b1) begin
          n_err++;
          $display("FAIL reset_out r%0d: got %h/%b expected 0000/1", r, b2.out, b2.zero);
        end
      end
      n_cmp++;
      if (b2.wrap !== 1'b0 || b3.busy_err !== 1'b0) begin
        n_err++;
        $display("FAIL reset_flags: got wrap=%b busy=%b expected 0/0", b2.wrap, b3.busy_err);
      end
      #8;
    end
    #1;
    b2.op = OP_NOP; b3.op = OP_NOP;
    reset = 1;
  endtask
  task automatic test_load;
    do2(OP_LOAD_ACC, 0, 0, 16'h0002, 16'h1234);
    do2(OP_LOAD_DATA, 1, 0, 16'h4321, 16'h0001);
    for (int r = 0; r < 2; r++) begin
      b2.rd_sel = 1'(r);
      #1;
      n_cmp++;
      if (b2.out !== m2[r]) begin
        n_err++;
        $display("FAIL load r%0d: got %h expected %h", r, b2.out, m2[r]);
      end
    end
  endtask
  task automatic test_wrap;
    logic [2:0] ops [3];
    ops = '{OP_INC, OP_DEC, OP_NOP};
    do2(OP_LOAD_DATA, 0, 0, 16'h0, 16'hFFFF);
    b2.rd_sel = 0;
    foreach (ops[i]) begin
      do2(ops[i], 0, 0, 16'h0, 16'h0);
      n_cmp++;
      if (b2.out !== m2[0] || b2.wrap !== mw2 || b2.zero !== (m2[0] == 16'h0)) begin
        n_err++;
        $display("FAIL wrap op%0d: got %h w=%b z=%b expected %h w=%b", ops[i], b2.out, b2.wrap, b2.zero, m2[0], mw2);
      end
    end
  endtask
  task automatic test_step;
    logic [15:0] steps [4];
    steps = '{16'hFFF8, 16'hFFF0, 16'h0008, 16'h0001};
    do2(OP_LOAD_DATA, 1, 0, 16'h0, 16'h0010);
    b2.rd_sel = 1;
    foreach (steps[i]) begin
      do2(OP_STEP, 1, 0, 16'h0, steps[i]);
      n_cmp++;
      if (b2.out !== m2[1] || b2.wrap !== mw2) begin
        n_err++;
        $display("FAIL step %h: got %h w=%b expected %h w=%b", steps[i], b2.out, b2.wrap, m2[1], mw2);
      end
    end
  endtask
  task automatic test_copy;
    do2(OP_LOAD_DATA, 0, 0, 16'h0, 16'hA5A5);
    do2(OP_LOAD_DATA, 1, 0, 16'h0, 16'h3C3C);
    b2.rd_sel = 1; b2.op = OP_COPY; b2.wr_sel = 1; b2.src_sel = 0;
    #2;
    n_cmp++;
    if (b2.out !== 16'h3C3C) begin
      n_err++;
      $display("FAIL copy_same_cycle: got %h expected 3c3c", b2.out);
    end
    @(posedge clk); #1;
    m2[1] = m2[0];
    mw2 = 0;
    n_cmp++;
    if (b2.out !== 16'hA5A5) begin
      n_err++;
      $display("FAIL copy_next_cycle: got %h expected a5a5", b2.out);
    end
  endtask
  task automatic test_random2;
    for (int n = 0; n < 150; n++) begin
      do2(3'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
          16'($urandom), ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      n_cmp++;
      if (b2.wrap !== mw2) begin
        n_err++;
        $display("FAIL rand2_wrap #%0d: got %b expected %b", n, b2.wrap, mw2);
      end
      for (int r = 0; r < 2; r++) begin
        b2.rd_sel = 1'(r);
        #1;
        n_cmp++;
        if (b2.out !== m2[r] || b2.zero !== (m2[r] == 16'h0)) begin
          n_err++;
          $display("FAIL rand2_reg #%0d r%0d: got %h z=%b expected %h", n, r, b2.out, b2.zero, m2[r]);
        end
      end
    end
    do2(OP_NOP, 0, 0, 16'h0, 16'h0);
  endtask
  task automatic test_bad_sel;
    do3(OP_LOAD_DATA, 0, 0, 16'h0, 16'h1111);
    do3(OP_LOAD_DATA, 2, 0, 16'h0, 16'h2222);
    do3(OP_LOAD_DATA, 3, 0, 16'h0, 16'h3333);
    n_cmp++;
    if (b3.busy_err !== 1'b1) begin
      n_err++;
      $display("FAIL bad_wr_busy: got %b expected 1", b3.busy_err);
    end
    do3(OP_INC, 0, 3, 16'h0, 16'h0);
    n_cmp++;
    if (b3.busy_err !== 1'b1) begin
      n_err++;
      $display("FAIL bad_src_busy: got %b expected 1", b3.busy_err);
    end
    do3(OP_NOP, 3, 3, 16'h0, 16'h0);
    n_cmp++;
    if (b3.busy_err !== 1'b0) begin
      n_err++;
      $display("FAIL busy_clear: got %b expected 0", b3.busy_err);
    end
    for (int r = 0; r < 4; r++) begin
      b3.rd_sel = 2'(r);
      #1;
      n_cmp++;
      if (b3.out !== ((r < 3) ? m3[r] : 16'h0)) begin
        n_err++;
        $display("FAIL bad_sel_reg r%0d: got %h expected %h", r, b3.out, (r < 3) ? m3[r] : 16'h0);
      end
    end
  endtask
  task automatic test_random3;
    for (int n = 0; n < 120; n++) begin
      do3(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          16'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom));
      n_cmp++;
      if (b3.wrap !== mw3 || b3.busy_err !== mb3) begin
        n_err++;
        $display("FAIL rand3_flags #%0d: got w=%b b=%b expected w=%b b=%b", n, b3.wrap, b3.busy_err, mw3, mb3);
      end
      for (int r = 0; r < 4; r++) begin
        b3.rd_sel = 2'(r);
        #1;
        n_cmp++;
        if (b3.out !== ((r < 3) ? m3[r] : 16'h0)) begin
          n_err++;
          $display("FAIL rand3_reg #%0d r%0d: got %h expected %h", n, r, b3.out, (r < 3) ? m3[r] : 16'h0);
        end
      end
    end
  endtask
  task automatic test_reset_mid;
    do2(OP_LOAD_DATA, 0, 0, 16'h0, 16'h7777);
    do3(OP_LOAD_DATA, 1, 0, 16'h0, 16'h8888);
    b2.op = OP_LOAD_DATA; b2.wr_sel = 0; b2.data_val = 16'h5555;
    b3.op = OP_LOAD_DATA; b3.wr_sel = 2; b3.src_sel = 0; b3.data_val = 16'h5555;
    #1;
    reset = 0;
    m2 = '{default: 16'h0}; m3 = '{default: 16'h0};
    for (int r = 0; r < 3; r++) begin
      b3.rd_sel = 2'(r);
      b2.rd_sel = 1'(r % 2);
      #1;
      n_cmp++;
      if (b3.out !== 16'h0 || b2.out !== 16'h0) begin
        n_err++;
        $display("FAIL reset_mid r%0d: got %h/%h expected 0000/0000", r, b2.out, b3.out);
      end
    end
    @(posedge clk); #2;
    reset = 1;
    b2.op = OP_NOP; b3.op = OP_NOP;
    b2.rd_sel = 0; b3.rd_sel = 2;
    #1;
    n_cmp++;
    if (b2.out !== 16'h0 || b3.out !== 16'h0) begin
      n_err++;
      $display("FAIL reset_discard: got %h/%h expected 0000/0000", b2.out, b3.out);
    end
    do2(OP_LOAD_ACC, 0, 0, 16'h00AB, 16'h0);
    n_cmp++;
    if (b2.out !== 16'h00AB) begin
      n_err++;
      $display("FAIL after_reset: got %h expected 00ab", b2.out);
    end
  endtask
  initial begin
    test_reset;
    test_load;
    test_wrap;
    test_step;
    test_copy;
    test_random2;
    test_bad_sel;
    test_random3;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
